module_decod_hamming: RTL and testbench

MODULE_DECOD_HAMMING -- requirements
Module: module_decod_hamming

---
 rtl/hamming_pkg.sv | 16 +
 rtl/hamming_syndrome.sv | 11 +
 rtl/module_decod_hamming.sv | 63 ++++++
 tb/tb_module_decod_hamming.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4) types, bit positions and data extraction
package hamming_pkg;
  typedef logic [6:0] codeword_t;
  typedef logic [3:0] data_t;
  typedef logic [2:0] syndrome_t;
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P3 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;
  function automatic data_t extract_data(codeword_t c);
    return {c[D3], c[D2], c[D1], c[D0]};
  endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational syndrome {s3,s2,s1} of a Hamming(7,4) codeword
module hamming_syndrome
  import hamming_pkg::*;
(
  input  codeword_t code,
  output syndrome_t syn
);
  assign syn = {code[P3] ^ code[D1] ^ code[D2] ^ code[D3],
                code[P2] ^ code[D0] ^ code[D2] ^ code[D3],
                code[P1] ^ code[D0] ^ code[D1] ^ code[D3]};
endmodule

// File: rtl/module_decod_hamming.sv
// module_decod_hamming: two-stage elastic Hamming(7,4) decoder with saturating corrected-word counter
module module_decod_hamming
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_syn,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  logic      s1_full;
  codeword_t s1_code;
  syndrome_t s1_syn;
  codeword_t fixed;
  logic      adv;
  logic      take;
  hamming_syndrome u_syn (.code(s1_code), .syn(s1_syn));
  assign adv      = s1_full && (!out_valid || out_ready);
  assign in_ready = !s1_full || adv;
  assign take     = in_valid && in_ready;
  assign fixed    = s1_code ^ ((s1_syn != '0) ? codeword_t'(7'd1 << (s1_syn - 3'd1)) : '0);
  // stage 1: capture accepted codeword, empty when it moves on with nothing behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_full <= 1'b0;
      s1_code <= '0;
    end else begin
      s1_full <= take ? 1'b1 : (adv ? 1'b0 : s1_full);
      if (take) s1_code <= in_code;
    end
  end
  // stage 2: load corrected result on advance, frozen while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_syn   <= '0;
    end else if (adv) begin
      out_valid <= 1'b1;
      out_data  <= extract_data(fixed);
      out_err   <= s1_syn != '0;
      out_syn   <= s1_syn;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  // count corrected words as they leave; clear has priority, no wrap at full scale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else if (clr_cnt) err_cnt <= '0;
    else if (out_valid && out_ready && out_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_module_decod_hamming.sv
// tb_module_decod_hamming: scoreboard bench for the Hamming decoder (default and 2-bit counter instances)
module tb_module_decod_hamming;
  typedef struct packed {
    logic [3:0] d;
    logic       e;
    logic [2:0] s;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [6:0] in_code = '0;
  logic       out_ready = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       in_ready, out_valid, out_err;
  logic [3:0] out_data;
  logic [2:0] out_syn;
  logic [7:0] err_cnt;
  logic       in_ready2, out_valid2, out_err2;
  logic [3:0] out_data2;
  logic [2:0] out_syn2;
  logic [1:0] err_cnt2;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  module_decod_hamming u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .out_syn(out_syn), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );
  module_decod_hamming #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_err(out_err2),
    .out_syn(out_syn2), .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
  );
  function automatic exp_t model(input logic [6:0] code);
    logic [6:0] c;
    int s;
    exp_t r;
    c = code;
    s = 0;
    for (int i = 0; i < 7; i++) if (c[i]) s = s ^ (i + 1);
    if (s != 0) c[s-1] = ~c[s-1];
    r.d = {c[6], c[5], c[4], c[2]};
    r.e = (s != 0);
    r.s = 3'(s);
    return r;
  endfunction
  task automatic scoreboard();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) q.delete();
      else begin
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got data=%h err=%b syn=%0d with no word outstanding", out_data, out_err, out_syn);
          end else begin
            e = q.pop_front();
            if ({out_data, out_err, out_syn} !== e) begin
              failures++;
              $display("FAIL sb_word got data=%h err=%b syn=%0d want data=%h err=%b syn=%0d",
                       out_data, out_err, out_syn, e.d, e.e, e.s);
            end
          end
        end
        if (in_valid && in_ready) q.push_back(model(in_code));
      end
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d words outstanding want 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got valid=%b err=%b want 0 0", out_valid, out_err);
    end
    checks++;
    if (out_data !== 4'h0 || out_syn !== 3'd0) begin
      failures++;
      $display("FAIL reset_data got data=%h syn=%0d want 0 0", out_data, out_syn);
    end
    checks++;
    if (err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", err_cnt, err_cnt2);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask
  task automatic test_single(input logic [6:0] c, input logic [3:0] d, input logic e,
                             input logic [2:0] s, input logic [7:0] cnt);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_code = c;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_%h got valid=%b want 0", c, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || out_err !== e || out_syn !== s) begin
      failures++;
      $display("FAIL single_%h got v=%b data=%h err=%b syn=%0d want v=1 data=%h err=%b syn=%0d",
               c, out_valid, out_data, out_err, out_syn, d, e, s);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_cnt !== cnt || err_cnt2 !== 2'(cnt)) begin
      failures++;
      $display("FAIL single_cnt_%h got %0d/%0d want %0d", c, err_cnt, err_cnt2, cnt);
    end
  endtask
  task automatic test_back_to_back();
    logic [6:0] w [3];
    logic [7:0] x [3];
    w = '{7'h00, 7'h02, 7'h7F};
    x = '{{4'h0, 1'b0, 3'd0}, {4'h0, 1'b1, 3'd2}, {4'hF, 1'b0, 3'd0}};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || {out_data, out_err, out_syn} !== x[i-2]) begin
          failures++;
          $display("FAIL b2b_%0d got v=%b %h/%b/%0d want v=1 %h/%b/%0d", i - 2, out_valid,
                   out_data, out_err, out_syn, x[i-2][7:4], x[i-2][3], x[i-2][2:0]);
        end
      end
      in_valid = i < 3;
      in_code = (i < 3) ? w[i] : 7'h00;
    end
    drain();
  endtask
  task automatic test_stall();
    logic [6:0] w [3];
    int k;
    w = '{7'h55, 7'h45, 7'h02};
    k = 0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_code = w[0];
    for (int c = 0; c < 5; c++) begin
      #1;
      if (in_ready) k++;
      @(posedge clk);
      #1;
      in_code = w[k < 3 ? k : 2];
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hB || out_err !== 1'b0 || out_syn !== 3'd0) begin
          failures++;
          $display("FAIL stall_hold_%0d got v=%b %h/%b/%0d want v=1 b/0/0", c, out_valid, out_data, out_err, out_syn);
        end
      end
    end
    #1;
    checks++;
    if (k != 2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_accept got accepted=%0d in_ready=%b want 2 0", k, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && k < 3; c++) begin
      #1;
      if (in_ready) k++;
      @(posedge clk);
      #1;
      in_code = w[k < 3 ? k : 2];
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (err_cnt !== 8'd4) begin
      failures++;
      $display("FAIL stall_cnt got %0d want 4", err_cnt);
    end
  endtask
  task automatic test_saturate();
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL clr_idle got %0d/%0d want 0/0", err_cnt, err_cnt2);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_code = 7'h45;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    checks++;
    if (err_cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL sat_cnt2 got %0d want 3", err_cnt2);
    end
    checks++;
    if (err_cnt !== 8'd5) begin
      failures++;
      $display("FAIL sat_cnt8 got %0d want 5", err_cnt);
    end
    in_valid = 1'b1;
    in_code = 7'h45;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1) begin
      failures++;
      $display("FAIL clr_setup got v=%b err=%b want 1 1", out_valid, out_err);
    end
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL clr_coincident got %0d/%0d want 0/0", err_cnt, err_cnt2);
    end
  endtask
  task automatic test_reset_midflight();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_code = 7'h55;
    @(posedge clk);
    #1;
    in_code = 7'h02;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_full got v=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0) begin
      failures++;
      $display("FAIL mid_async got v=%b data=%h want 0 0", out_valid, out_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL mid_stale_%0d got v=%b in_ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask
  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_single(7'h55, 4'hB, 1'b0, 3'd0, 8'd0);
    test_single(7'h45, 4'hB, 1'b1, 3'd5, 8'd1);
    test_back_to_back();
    test_stall();
    test_saturate();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
